limit_scheduler: RTL
====================

Name: limit_scheduler

Overview:
- Time-shares one signed clip/limit datapath among N_CH servo/DAC value producers.
- Arbitration is round-robin.
- Limits are per-channel and runtime-configurable.
- Emits one truncated output word per grant, tagged with channel index and a clip flag.
- Sits between PI/servo accumulators and DAC serializers; keeps per-channel sticky clip status for the host.

Parameters:
CH_BITS, 2, channel index width; N_CH = 2**CH_BITS.
INPUT_BITS, 16, signed width of request values and limit registers.
OUTPUT_MSB, 15, top bit of the emitted slice.
OUTPUT_LSB, 5, bottom bit of the emitted slice; OUT_W = OUTPUT_MSB-OUTPUT_LSB+1.
RESET_MIN, 0, reset value of every channel min register.
RESET_MAX, 16'h7fff, reset value of every channel max register.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
req  in  N_CH  per-channel request level.
value  in  N_CH*INPUT_BITS  packed signed values; channel i at [i*INPUT_BITS +: INPUT_BITS].
ack  out  N_CH  one-hot, 1-cycle acknowledge: value captured.
cfg_we  in  1  limit register write strobe.
cfg_addr  in  CH_BITS+1  {channel, sel}; sel 0 = min, 1 = max.
cfg_data  in  INPUT_BITS  signed limit value.
out_valid  out  1  1-cycle output strobe.
out_channel  out  CH_BITS  channel of the current output.
out_value  out  OUT_W  limited value slice.
out_clipped  out  1  current output was clipped.
clip_sticky  out  N_CH  per-channel sticky clip flags.
clip_clear  in  N_CH  per-channel sticky clear mask, 1-cycle pulse.

Behaviour:
- Reset (async assert, sync release)
  - Outputs: ack, out_valid, out_channel, out_value, out_clipped, clip_sticky all 0.
  - Limit registers: min = RESET_MIN, max = RESET_MAX.
  - Round-robin pointer = 0; FSM = IDLE.
  - Reset mid-transaction discards it: no ack/out_valid afterwards; requester keeps req high and is re-served.
- FSM states: IDLE, LATCH, LIMIT, EMIT.
  - IDLE: if any req bit is set at the edge, pick winner = first set bit at or after the pointer (wrapping), then go to LATCH.
  - LATCH (1 cycle):
    - ack[winner] = 1.
    - Capture value[winner], min[winner], max[winner] into holding registers.
    - Pointer <= winner+1 mod N_CH.
    - Next state LIMIT.
  - LIMIT (1 cycle), signed compares on captured operands:
    - v < min: result = min[OUTPUT_MSB:OUTPUT_LSB], clip = 1.
    - else v > max: result = max[OUTPUT_MSB:OUTPUT_LSB], clip = 1.
    - else: result = v[OUTPUT_MSB:OUTPUT_LSB], clip = 0.
    - Next state EMIT.
  - EMIT (1 cycle):
    - out_valid = 1; out_channel, out_value, out_clipped driven.
    - out_channel/out_value/out_clipped hold until the next EMIT.
    - If any req is set, arbitrate in this cycle and go to LATCH; else go to IDLE.
- Timing
  - Latency: req sampled at edge k → ack high in cycle k+1 → out_valid high in cycle k+3.
  - Back-to-back throughput: one result per 3 cycles.
- Handshake
  - Requester holds req and a stable value until ack.
  - Requester drops req in the ack cycle unless it wants another sample. A req still high the cycle after ack counts as a new request.
  - If req drops before it is sampled, no transaction occurs.
- Min greater than max (misconfiguration): the min test has priority; result = min, clip = 1.
- Config writes take effect on the next edge.
  - A write during LIMIT/EMIT to the channel in flight does not affect that transaction (snapshot taken in LATCH).
  - A write in the same cycle as LATCH for that channel: LATCH captures the old value.
- Sticky clip flags
  - clip_sticky[i] sets in EMIT when out_clipped = 1 and out_channel = i.
  - clip_clear[i] clears bit i.
  - Set and clear in the same cycle on the same bit: set wins.
- All-req-high fairness: grant order is 0,1,2,3,0,… with no starvation. Worst-case wait is N_CH*3 cycles.

Test Plan:
- Reset, then req[1]=1, value1=16'h1234 → ack[1] one cycle later. out_valid two cycles after ack: channel 1, out_value = 0x1234[15:5] = 0x091, clipped 0.
- Channel 0 value = -5 (16'hfffb), default min 0 → out_value 0, out_clipped 1, clip_sticky[0] = 1. Then pulse clip_clear[0] → 0.
- Write max ch2 = 16'h0400, then value2 = 16'h2000 → out_value 0x020, clipped 1. Value2 = 16'h0400 → 0x020, clipped 0 (equal is not clipped).
- req = 4'b1111 held (dropped per ack, reasserted next cycle) → grant order 0,1,2,3,0; out_valid every 3 cycles; never two ack bits set at once.
- Assert rst_n=0 in the LIMIT cycle of a ch3 transaction → out_valid never fires for it. After release with req[3] still high, ch3 is served with the reset limits.
- cfg write to ch1 max in the same cycle as ch1 LATCH → that result uses the old max; the next ch1 transaction uses the new max.

Source files
------------

// File: rtl/limit_scheduler.sv
// Round-robin scheduler sharing one signed clip/limit datapath among N_CH producers.
// Per-channel runtime min/max limits, truncated output slice, sticky clip flags.
//   state   | meaning
//   S_IDLE  | waiting for any request
//   S_LATCH | ack winner, snapshot value and limits, advance pointer
//   S_LIMIT | signed compare on snapshot, register result
//   S_EMIT  | out_valid strobe, re-arbitrate
module limit_scheduler #(
  parameter int CH_BITS = 2,
  parameter int INPUT_BITS = 16,
  parameter int OUTPUT_MSB = 15,
  parameter int OUTPUT_LSB = 5,
  parameter logic [INPUT_BITS-1:0] RESET_MIN = '0,
  parameter logic [INPUT_BITS-1:0] RESET_MAX = 16'h7fff,
  localparam int N_CH = 2**CH_BITS,
  localparam int OUT_W = OUTPUT_MSB - OUTPUT_LSB + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0]            req,
  input  logic [N_CH*INPUT_BITS-1:0] value,
  output logic [N_CH-1:0]            ack,
  input  logic                       cfg_we,
  input  logic [CH_BITS:0]           cfg_addr,
  input  logic [INPUT_BITS-1:0]      cfg_data,
  output logic                       out_valid,
  output logic [CH_BITS-1:0]         out_channel,
  output logic [OUT_W-1:0]           out_value,
  output logic                       out_clipped,
  output logic [N_CH-1:0]            clip_sticky,
  input  logic [N_CH-1:0]            clip_clear
);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_LIMIT, S_EMIT} state_t;

  state_t state_q, state_d;
  logic [CH_BITS-1:0] ptr_q, win_q, grant_idx, scan_idx;
  logic grant_any, start;
  logic [N_CH-1:0] ack_q, sticky_q, sticky_d;
  logic signed [INPUT_BITS-1:0] min_r_q [N_CH];
  logic signed [INPUT_BITS-1:0] max_r_q [N_CH];
  logic signed [INPUT_BITS-1:0] v_hold_q, min_hold_q, max_hold_q;
  logic [OUT_W-1:0] res_value, out_value_q;
  logic res_clip, out_valid_q, out_clipped_q;
  logic [CH_BITS-1:0] out_channel_q;
  logic [CH_BITS-1:0] cfg_ch;
  logic cfg_sel;

  assign cfg_sel = cfg_addr[0];
  assign cfg_ch  = cfg_addr[CH_BITS:1];

  // First requesting channel at or after the pointer, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 0; k < N_CH; k++) begin
      scan_idx = ptr_q + CH_BITS'(k);
      if (!grant_any && req[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign start = grant_any && (state_q == S_IDLE || state_q == S_EMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_any) state_d = S_LATCH;
      S_LATCH: state_d = S_LIMIT;
      S_LIMIT: state_d = S_EMIT;
      S_EMIT:  state_d = grant_any ? S_LATCH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Min test first so a misconfigured min > max still yields min.
  always_comb begin
    res_clip  = 1'b1;
    res_value = v_hold_q[OUTPUT_MSB:OUTPUT_LSB];
    if (v_hold_q < min_hold_q) res_value = min_hold_q[OUTPUT_MSB:OUTPUT_LSB];
    else if (v_hold_q > max_hold_q) res_value = max_hold_q[OUTPUT_MSB:OUTPUT_LSB];
    else res_clip = 1'b0;
  end

  always_comb begin
    sticky_d = sticky_q & ~clip_clear;
    if (state_q == S_EMIT && out_clipped_q) sticky_d[out_channel_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      win_q         <= '0;
      ack_q         <= '0;
      v_hold_q      <= '0;
      min_hold_q    <= '0;
      max_hold_q    <= '0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      out_value_q   <= '0;
      out_clipped_q <= 1'b0;
      sticky_q      <= '0;
      for (int i = 0; i < N_CH; i++) begin
        min_r_q[i] <= RESET_MIN;
        max_r_q[i] <= RESET_MAX;
      end
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      if (start) begin
        ack_q[grant_idx] <= 1'b1;
        win_q            <= grant_idx;
      end
      if (state_q == S_LATCH) begin
        v_hold_q   <= value[int'(win_q)*INPUT_BITS +: INPUT_BITS];
        min_hold_q <= min_r_q[win_q];
        max_hold_q <= max_r_q[win_q];
        ptr_q      <= win_q + CH_BITS'(1);
      end
      out_valid_q <= (state_q == S_LIMIT);
      if (state_q == S_LIMIT) begin
        out_channel_q <= win_q;
        out_value_q   <= res_value;
        out_clipped_q <= res_clip;
      end
      sticky_q <= sticky_d;
      // Snapshot in LATCH reads the pre-write value when both land on one edge.
      if (cfg_we) begin
        if (cfg_sel) max_r_q[cfg_ch] <= cfg_data;
        else         min_r_q[cfg_ch] <= cfg_data;
      end
    end
  end

  assign ack         = ack_q;
  assign out_valid   = out_valid_q;
  assign out_channel = out_channel_q;
  assign out_value   = out_value_q;
  assign out_clipped = out_clipped_q;
  assign clip_sticky = sticky_q;

endmodule
